axi4_slave_read_burst_ctrl: RTL and testbench
=============================================

# axi4_slave_read_burst_ctrl

Read-burst sequencer for the AXI4 slave read path. It takes one accepted read-address transfer, meaning the registered transfer pulse and the latched AR fields from the slave read-address block. It then generates the per-beat memory read addresses for FIXED, INCR and WRAP bursts and drives the AXI4 R channel with correct rid, rresp and rlast. It sits between the read-address block, the slave's synchronous-read memory and the R-channel output port, and tells the upstream block when it is busy.

## Interface
- ADDR_WIDTH, 32: AXI byte-address width.
- DATA_WIDTH, 32: R-channel and memory data width; power of two, 8..1024.
- ID_WIDTH, 4: transaction ID width.
- BURST_LENGTH, 8: arlen width.
- MEM_DEPTH, 1024: memory depth in DATA_WIDTH words.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- ar_transfer_occurred  in  1  single-cycle pulse: one AR transfer accepted, latched fields valid.
- latched_araddr  in  ADDR_WIDTH  start byte address.
- latched_arid  in  ID_WIDTH  transaction ID.
- latched_arlen  in  BURST_LENGTH  beats minus one.
- latched_arsize  in  3  log2 of bytes per beat.
- latched_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- mem_rd_en  out  1  memory read strobe; data is returned the following cycle.
- mem_addr  out  log2(MEM_DEPTH)  word address, equal to byte address >> log2(DATA_WIDTH/8).
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after mem_rd_en.
- rvalid  out  1  R-channel valid.
- rready  in  1  R-channel ready.
- rdata  out  DATA_WIDTH  read data.
- rid  out  ID_WIDTH  equals the latched arid.
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- rlast  out  1  final beat of the burst.
- busy  out  1  a burst is in progress; new pulses are not accepted.
- overrun  out  1  sticky flag: a pulse arrived while busy.

## Operation
- States are IDLE, ISSUE, WAIT, RESP.
- **IDLE:** on an ar_transfer_occurred pulse, register the fields, load the beat counter with arlen, set busy and go to ISSUE.
- **ISSUE:** drive mem_rd_en = 1 and mem_addr from the current beat address, then go to WAIT.
  - mem_rd_en is suppressed when the beat carries an error.
- **WAIT:** register mem_rdata into rdata (0 on error beats), set rvalid, rresp and rlast (rlast = counter == 0), then go to RESP.
- **RESP:** hold rvalid, rdata, rresp and rlast stable until rready.
  - On rvalid && rready with counter != 0: decrement the counter, advance the address and go to ISSUE.
  - On the handshake with counter == 0: clear rvalid and busy and go to IDLE.
- **Beat size:** bytes = 1 << arsize.
- **FIXED:** every beat uses the start address.
- **INCR:** next address = (addr & ~(bytes-1)) + bytes, computed modulo 2^ADDR_WIDTH.
  - The first beat may be unaligned; later beats are aligned.
  - No 4 KB boundary check is performed.
- **WRAP:** total = bytes*(arlen+1) and lower = addr & ~(total-1).
  - next = addr + bytes; if next == lower + total, next = lower.
- **SLVERR (whole burst):** applies when burst == 11, when bytes > DATA_WIDTH/8, or when a WRAP burst has arlen not in {1, 3, 7, 15}.
  - All arlen+1 beats are still returned with rdata = 0.
- **DECERR (per beat):** applies to any beat whose byte address is >= MEM_DEPTH*DATA_WIDTH/8.
  - Such beats return rdata = 0.
  - SLVERR takes priority over DECERR.
- **Pulse while busy:** the pulse is dropped, overrun is set and the current burst is unaffected.
  - overrun clears only on reset.
- **Pulse in IDLE** is always accepted.

## Timing
- **Reset values:** mem_rd_en, rvalid, rlast, busy and overrun are 0; rdata is 0, rid is 0, rresp is 00 and mem_addr is 0; state is IDLE.
- Reset mid-burst aborts immediately with no further beats.
- **First beat:** with the pulse in cycle T, busy is high from T+1, mem_rd_en is high in T+1, and rvalid is high from T+3.
- **Following beats:** with a handshake in cycle C, mem_rd_en is high in C+1 and the next rvalid is high in C+3.
  - Peak throughput is one beat per 3 cycles.
- **After the last beat:** with the last handshake in cycle C, rvalid and busy are low in C+1, and a pulse in C+1 is accepted.
- rvalid never drops without a handshake, and R outputs never change while rvalid && !rready.

## Test plan
- **INCR, aligned, OKAY:** addr 0x100, len 3, size 2, rready tied 1 → mem_addr 0x40, 0x41, 0x42, 0x43; four beats, rlast on beat 4 only; first rvalid at T+3; rresp 00.
- **WRAP:** addr 0x38, len 3, size 2 → byte addresses 0x38, 0x3C, 0x30, 0x34.
- **FIXED and unaligned INCR:**
  - FIXED, addr 0x20, len 2 → three beats all at word 0x08.
  - INCR, addr 0x13, size 2 → byte addresses 0x13, 0x14, 0x18.
- **Errors:**
  - burst 11, len 1 → two beats, rresp 10, rdata 0, no mem_rd_en.
  - WRAP with len 2 → SLVERR.
  - INCR at byte 0xFFC with MEM_DEPTH 1024, len 1 → beat 1 OKAY, beat 2 DECERR.
- **Backpressure:** rready low for 5 cycles on beat 2 → rdata, rresp and rlast held stable, no extra mem_rd_en, burst completes correctly.
- **Overrun and reset:**
  - A second pulse mid-burst → overrun = 1, current burst intact, no second burst.
  - rst low mid-burst → all outputs return to reset values on the next edge, after which a new burst runs normally.

Source files
------------

// File: rtl/axi4_slave_read_burst_ctrl.sv
// AXI4 slave read-burst sequencer.
// Takes one accepted AR transfer and walks its beats. Each beat reads the
// synchronous memory and presents one R-channel response. Burst types are
// FIXED, INCR and WRAP. SLVERR covers the whole burst; DECERR is per beat.
module axi4_slave_read_burst_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int BURST_LENGTH = 8,
    parameter int MEM_DEPTH    = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ar_transfer_occurred,
    input  logic [ADDR_WIDTH-1:0]        latched_araddr,
    input  logic [ID_WIDTH-1:0]          latched_arid,
    input  logic [BURST_LENGTH-1:0]      latched_arlen,
    input  logic [2:0]                   latched_arsize,
    input  logic [1:0]                   latched_arburst,
    output logic                         mem_rd_en,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic [ID_WIDTH-1:0]          rid,
    output logic [1:0]                   rresp,
    output logic                         rlast,
    output logic                         busy,
    output logic                         overrun
);
    localparam int MAW = $clog2(MEM_DEPTH);
    localparam int BSH = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] MEM_WORDS = ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Burst context captured when the transfer is accepted
    typedef struct packed {
        logic [ID_WIDTH-1:0]     id;
        logic [BURST_LENGTH-1:0] len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    slverr;
    } ctx_t;

    state_t                  state, state_nx;
    ctx_t                    ctx;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [BURST_LENGTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0]   bytes, total, lower, step_addr, next_addr;
    logic                    slverr_in, wrap_len_ok, decerr, beat_err, hs;

    assign hs  = rvalid && rready;
    assign rid = ctx.id;

    // Burst-wide error decision, made on the incoming fields
    always_comb begin
        wrap_len_ok = (latched_arlen == BURST_LENGTH'(1)) || (latched_arlen == BURST_LENGTH'(3)) ||
                      (latched_arlen == BURST_LENGTH'(7)) || (latched_arlen == BURST_LENGTH'(15));
        slverr_in   = (latched_arburst == 2'b11) ||
                      (int'(latched_arsize) > BSH) ||
                      ((latched_arburst == 2'b10) && !wrap_len_ok);
    end

    // Per-beat decode error and the address of the following beat
    always_comb begin
        decerr    = (addr_q >> BSH) >= MEM_WORDS;
        beat_err  = ctx.slverr || decerr;
        bytes     = ADDR_WIDTH'(1) << ctx.size;
        total     = bytes * (ADDR_WIDTH'(ctx.len) + ADDR_WIDTH'(1));
        lower     = addr_q & ~(total - ADDR_WIDTH'(1));
        step_addr = addr_q + bytes;
        unique case (ctx.burst)
            2'b00:   next_addr = addr_q;
            2'b01:   next_addr = (addr_q & ~(bytes - ADDR_WIDTH'(1))) + bytes;
            2'b10:   next_addr = (step_addr == lower + total) ? lower : step_addr;
            default: next_addr = step_addr;  // SLVERR burst, address is never used
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (ar_transfer_occurred) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = RESP;
            RESP:    if (hs) state_nx = (cnt == '0) ? IDLE : ISSUE;
            default: state_nx = IDLE;
        endcase
    end

    // Memory strobe and busy follow directly from the state
    always_comb begin
        busy      = (state != IDLE);
        mem_rd_en = (state == ISSUE) && !beat_err;
        mem_addr  = (state == ISSUE) ? addr_q[BSH +: MAW] : '0;
    end

    // Burst context, beat counter, address walk and the R-channel registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctx     <= '0;
            addr_q  <= '0;
            cnt     <= '0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= 2'b00;
            rlast   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (ar_transfer_occurred) begin
                if (state == IDLE) begin
                    ctx    <= '{id: latched_arid, len: latched_arlen, size: latched_arsize,
                                burst: latched_arburst, slverr: slverr_in};
                    addr_q <= latched_araddr;
                    cnt    <= latched_arlen;
                end else begin
                    overrun <= 1'b1;
                end
            end
            if (state == WAIT) begin
                rvalid <= 1'b1;
                rdata  <= beat_err ? '0 : mem_rdata;
                rresp  <= ctx.slverr ? 2'b10 : (decerr ? 2'b11 : 2'b00);
                rlast  <= (cnt == '0);
            end
            if (state == RESP && hs) begin
                rvalid <= 1'b0;
                if (cnt != '0) begin
                    cnt    <= cnt - BURST_LENGTH'(1);
                    addr_q <= next_addr;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi4_slave_read_burst_ctrl.sv
// Directed bench for the read-burst sequencer. Stimulus pushes the expected
// memory word addresses and R beats. A negedge monitor pops and compares
// them as the DUT strobes memory or completes an R handshake.
module tb_axi4_slave_read_burst_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ar_transfer_occurred = 1'b0;
    logic [31:0] latched_araddr = '0;
    logic [3:0]  latched_arid = '0;
    logic [7:0]  latched_arlen = '0;
    logic [2:0]  latched_arsize = '0;
    logic [1:0]  latched_arburst = '0;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        rlast;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    axi4_slave_read_burst_ctrl dut (
        .clk(clk), .rst(rst),
        .ar_transfer_occurred(ar_transfer_occurred),
        .latched_araddr(latched_araddr), .latched_arid(latched_arid),
        .latched_arlen(latched_arlen), .latched_arsize(latched_arsize),
        .latched_arburst(latched_arburst),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
        .rresp(rresp), .rlast(rlast), .busy(busy), .overrun(overrun)
    );

    function automatic logic [31:0] mv(input logic [9:0] w);
        return 32'hC0DE_0000 + 32'(w);
    endfunction

    // Synchronous-read memory model
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mv(mem_addr);

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t      beat_q[$];
    logic [9:0] addr_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic       hold = 1'b0;
    beat_t      held = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ea(input logic [9:0] w);
        addr_q.push_back(w);
    endtask

    task automatic eb(input logic [31:0] d, input logic [3:0] id, input logic [1:0] resp, input logic last);
        beat_q.push_back('{data: d, id: id, resp: resp, last: last});
    endtask

    // Monitor: memory strobes, R handshakes and stability under backpressure
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            hold <= 1'b0;
        end else begin
            if (mem_rd_en) begin
                if (addr_q.size() == 0) chk("unexpected mem_rd_en", 1, 0);
                else chk("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
            end
            if (hold) begin
                chk("rvalid held", 64'(rvalid), 1);
                chk("R outputs held", 64'({rdata, rid, rresp, rlast}), 64'(held));
            end
            if (rvalid && rready) begin
                if (beat_q.size() == 0) chk("unexpected beat", 1, 0);
                else begin
                    e = beat_q.pop_front();
                    chk("rdata", 64'(rdata), 64'(e.data));
                    chk("rid", 64'(rid), 64'(e.id));
                    chk("rresp", 64'(rresp), 64'(e.resp));
                    chk("rlast", 64'(rlast), 64'(e.last));
                end
            end
            hold <= rvalid && !rready;
            held <= '{data: rdata, id: rid, resp: rresp, last: rlast};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        latched_araddr = a; latched_arid = id; latched_arlen = len;
        latched_arsize = size; latched_arburst = burst;
        ar_transfer_occurred = 1'b1;
        tick();
        ar_transfer_occurred = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin tick(); n++; end
        chk("burst completes", 64'(busy), 0);
    endtask

    task automatic wait_rvalid();
        int n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        chk("rvalid arrives", 64'(rvalid), 1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst mem_rd_en", 64'(mem_rd_en), 0);
        chk("rst mem_addr", 64'(mem_addr), 0);
        chk("rst rvalid", 64'(rvalid), 0);
        chk("rst rdata", 64'(rdata), 0);
        chk("rst rid", 64'(rid), 0);
        chk("rst rresp", 64'(rresp), 0);
        chk("rst rlast", 64'(rlast), 0);
        chk("rst busy", 64'(busy), 0);
        chk("rst overrun", 64'(overrun), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        chk_reset_outputs();
        rst = 1'b1;
        tick();

        // INCR aligned 0x100, len 3, size 2, with first-beat and end timing
        for (int i = 0; i < 4; i++) begin
            ea(10'h40 + 10'(i));
            eb(mv(10'h40 + 10'(i)), 4'h1, 2'b00, i == 3);
        end
        pulse(32'h100, 4'h1, 8'd3, 3'd2, 2'b01);
        chk("T+1 busy", 64'(busy), 1);
        chk("T+1 mem_rd_en", 64'(mem_rd_en), 1);
        chk("T+1 rvalid", 64'(rvalid), 0);
        tick();
        chk("T+2 rvalid", 64'(rvalid), 0);
        tick();
        chk("T+3 rvalid", 64'(rvalid), 1);
        repeat (9) tick();
        chk("last beat rlast", 64'({rvalid, rlast}), 64'b11);
        tick();
        chk("after last busy/rvalid", 64'({busy, rvalid}), 0);

        // WRAP 0x38, len 3: 0x38 0x3C 0x30 0x34, issued in the cycle busy falls
        ea(10'h0E); eb(mv(10'h0E), 4'h2, 2'b00, 0);
        ea(10'h0F); eb(mv(10'h0F), 4'h2, 2'b00, 0);
        ea(10'h0C); eb(mv(10'h0C), 4'h2, 2'b00, 0);
        ea(10'h0D); eb(mv(10'h0D), 4'h2, 2'b00, 1);
        pulse(32'h38, 4'h2, 8'd3, 3'd2, 2'b10);
        wait_idle();

        // FIXED 0x20, len 2: word 0x08 three times
        for (int i = 0; i < 3; i++) begin
            ea(10'h08); eb(mv(10'h08), 4'h3, 2'b00, i == 2);
        end
        pulse(32'h20, 4'h3, 8'd2, 3'd2, 2'b00);
        wait_idle();

        // Unaligned INCR 0x13: 0x13 0x14 0x18
        ea(10'h04); eb(mv(10'h04), 4'h4, 2'b00, 0);
        ea(10'h05); eb(mv(10'h05), 4'h4, 2'b00, 0);
        ea(10'h06); eb(mv(10'h06), 4'h4, 2'b00, 1);
        pulse(32'h13, 4'h4, 8'd2, 3'd2, 2'b01);
        wait_idle();

        // Reserved burst type: SLVERR, no memory reads
        eb(32'h0, 4'h5, 2'b10, 0);
        eb(32'h0, 4'h5, 2'b10, 1);
        pulse(32'h40, 4'h5, 8'd1, 3'd2, 2'b11);
        wait_idle();

        // WRAP with len 2: SLVERR
        for (int i = 0; i < 3; i++) eb(32'h0, 4'h6, 2'b10, i == 2);
        pulse(32'h0, 4'h6, 8'd2, 3'd2, 2'b10);
        wait_idle();

        // Beat wider than the data bus: SLVERR
        eb(32'h0, 4'h7, 2'b10, 1);
        pulse(32'h0, 4'h7, 8'd0, 3'd3, 2'b01);
        wait_idle();

        // INCR crossing the end of memory: OKAY then DECERR
        ea(10'h3FF); eb(mv(10'h3FF), 4'h8, 2'b00, 0);
        eb(32'h0, 4'h8, 2'b11, 1);
        pulse(32'hFFC, 4'h8, 8'd1, 3'd2, 2'b01);
        wait_idle();

        // Backpressure: rready low 5 cycles on beat 2
        for (int i = 0; i < 3; i++) begin
            ea(10'h80 + 10'(i));
            eb(mv(10'h80 + 10'(i)), 4'h9, 2'b00, i == 2);
        end
        rready = 1'b0;
        pulse(32'h200, 4'h9, 8'd2, 3'd2, 2'b01);
        wait_rvalid();
        rready = 1'b1;
        tick();
        rready = 1'b0;
        wait_rvalid();
        repeat (5) tick();
        rready = 1'b1;
        wait_idle();

        // Pulse mid-burst: overrun set, second burst dropped
        for (int i = 0; i < 4; i++) begin
            ea(10'hC0 + 10'(i));
            eb(mv(10'hC0 + 10'(i)), 4'hA, 2'b00, i == 3);
        end
        pulse(32'h300, 4'hA, 8'd3, 3'd2, 2'b01);
        tick(); tick();
        pulse(32'h0, 4'hE, 8'd0, 3'd2, 2'b01);
        wait_idle();
        chk("overrun set", 64'(overrun), 1);
        chk("no dropped-burst beats", 64'(beat_q.size() + addr_q.size()), 0);

        // Reset mid-burst, then a clean burst
        ea(10'h100); eb(mv(10'h100), 4'hB, 2'b00, 0);
        pulse(32'h400, 4'hB, 8'd3, 3'd2, 2'b01);
        wait_rvalid();
        tick();
        rst = 1'b0;
        #1;
        beat_q.delete();
        addr_q.delete();
        chk_reset_outputs();
        tick();
        chk_reset_outputs();
        rst = 1'b1;
        tick();
        ea(10'h20); eb(mv(10'h20), 4'hC, 2'b00, 0);
        ea(10'h21); eb(mv(10'h21), 4'hC, 2'b00, 1);
        pulse(32'h80, 4'hC, 8'd1, 3'd2, 2'b01);
        wait_idle();
        tick();

        chk("beat queue drained", 64'(beat_q.size()), 0);
        chk("addr queue drained", 64'(addr_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
